// File: rtl/apb_spi_pkg.sv
// Shared register map, bit positions and engine state encoding for the APB SPI master.
package apb_spi_pkg;

  localparam logic [2:0] CTRL_A   = 3'd0;
  localparam logic [2:0] CLKDIV_A = 3'd1;
  localparam logic [2:0] STATUS_A = 3'd2;
  localparam logic [2:0] TXDATA_A = 3'd3;
  localparam logic [2:0] RXDATA_A = 3'd4;

  localparam int CTRL_W     = 11;
  localparam int C_EN       = 0;
  localparam int C_CPOL     = 1;
  localparam int C_CPHA     = 2;
  localparam int C_SS_HOLD  = 3;
  localparam int C_SS_SEL   = 4;
  localparam int C_LSB      = 7;
  localparam int C_IE_TXE   = 8;
  localparam int C_IE_RXNE  = 9;
  localparam int C_IE_OVF   = 10;

  localparam int S_BUSY     = 0;
  localparam int S_TX_FULL  = 1;
  localparam int S_TX_EMPTY = 2;
  localparam int S_RX_FULL  = 3;
  localparam int S_RX_EMPTY = 4;
  localparam int S_RX_OVF   = 5;
  localparam int S_TX_LVL   = 8;
  localparam int S_RX_LVL   = 16;

  typedef enum logic [2:0] {IDLE, LOAD, LEAD, TRAIL, DONE} eng_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO; a push while full or a pop while empty is ignored.
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     gclk,
  input  logic                     grst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  // full/empty come from the pre-edge count, so a push on a full FIFO loses even with a pop
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign dout    = mem[rp];

  always_ff @(posedge gclk)
    if (do_push) mem[wp] <= din;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/apb_spi_master.sv
// APB3 slave SPI master: CTRL/CLKDIV/STATUS registers, TX/RX FIFOs and a
// shift engine supporting all CPOL/CPHA modes, LSB-first and held selects.
module apb_spi_master
  import apb_spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_SS     = 2,
  parameter int DIV_W      = 8
) (
  input  logic              SYSCLK,
  input  logic              NSYSRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              SPI_CLK,
  output logic              SPI_DO,
  input  logic              SPI_DI,
  output logic [NUM_SS-1:0] SPI_SS_N,
  output logic              IRQ
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(DATA_W + 1);

  logic gclk, grst_n;
  assign gclk   = SYSCLK;
  assign grst_n = NSYSRESET;

  logic [CTRL_W-1:0] ctrl;
  logic [DIV_W-1:0]  clkdiv;
  logic              rx_ovf, acc_ok;
  logic              setup, access;
  logic [2:0]        ra;
  logic [31:0]       status, rdata_c;
  logic              err_c;

  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_W-1:0] tx_dout, rx_dout;
  logic [LW-1:0]     tx_lvl, rx_lvl;

  eng_state_t        state;
  logic [DIV_W-1:0]  cnt, div_q;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic              cpol_q, cpha_q, lsb_q, ss_on;
  logic              busy, start, half_done, ovf_set;

  wire unused_ok = ^{PADDR[7:5], PADDR[1:0], PWDATA};

  assign PREADY = 1'b1;
  assign setup  = PSEL & ~PENABLE;
  assign access = PSEL & PENABLE;
  assign ra     = PADDR[4:2];

  // ---------------- APB decode: outcome fixed in the setup phase ----------------
  always_comb begin
    status = '0;
    status[S_BUSY]            = busy;
    status[S_TX_FULL]         = tx_full;
    status[S_TX_EMPTY]        = tx_empty;
    status[S_RX_FULL]         = rx_full;
    status[S_RX_EMPTY]        = rx_empty;
    status[S_RX_OVF]          = rx_ovf;
    status[S_TX_LVL +: 8]     = 8'(tx_lvl);
    status[S_RX_LVL +: 8]     = 8'(rx_lvl);
  end

  always_comb begin
    err_c   = 1'b0;
    rdata_c = '0;
    case (ra)
      CTRL_A:   rdata_c = 32'(ctrl);
      CLKDIV_A: rdata_c = 32'(clkdiv);
      STATUS_A: begin
        err_c   = PWRITE;
        rdata_c = status;
      end
      TXDATA_A: err_c = ~PWRITE | tx_full;
      RXDATA_A: begin
        err_c = PWRITE | rx_empty;
        if (!rx_empty) rdata_c = 32'(rx_dout);
      end
      default:  err_c = 1'b1;
    endcase
    if (PWRITE || err_c) rdata_c = '0;
  end

  // acc_ok carries the setup-phase verdict so the access phase acts on the same decision
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
      acc_ok  <= 1'b0;
    end else if (setup) begin
      PRDATA  <= rdata_c;
      PSLVERR <= err_c;
      acc_ok  <= ~err_c;
    end else if (!access) begin
      PSLVERR <= 1'b0;
    end
  end

  assign tx_push = access &  PWRITE & (ra == TXDATA_A) & acc_ok;
  assign rx_pop  = access & ~PWRITE & (ra == RXDATA_A) & acc_ok;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      ctrl   <= '0;
      clkdiv <= '0;
      rx_ovf <= 1'b0;
      IRQ    <= 1'b0;
    end else begin
      if (access && PWRITE && ra == CTRL_A)   ctrl   <= PWDATA[CTRL_W-1:0];
      if (access && PWRITE && ra == CLKDIV_A) clkdiv <= PWDATA[DIV_W-1:0];
      if (ovf_set)
        rx_ovf <= 1'b1;
      else if (access && PWRITE && ra == STATUS_A && PWDATA[S_RX_OVF])
        rx_ovf <= 1'b0;
      IRQ <= (ctrl[C_IE_TXE] & tx_empty) | (ctrl[C_IE_RXNE] & ~rx_empty) |
             (ctrl[C_IE_OVF] & rx_ovf);
    end
  end

  // ---------------- FIFOs ----------------
  spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .gclk(gclk), .grst_n(grst_n), .push(tx_push), .din(PWDATA[DATA_W-1:0]),
    .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .level(tx_lvl)
  );

  spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .gclk(gclk), .grst_n(grst_n), .push(rx_push), .din(rx_sh),
    .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .level(rx_lvl)
  );

  // ---------------- shift engine ----------------
  function automatic logic out_bit(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] d, input logic b,
                                                 input logic lsb);
    return lsb ? {b, d[DATA_W-1:1]} : {d[DATA_W-2:0], b};
  endfunction

  assign busy      = (state != IDLE);
  assign half_done = (cnt == div_q);
  assign start     = (state == IDLE || state == DONE) && ctrl[C_EN] && !tx_empty;
  assign tx_pop    = start;
  assign rx_push   = (state == DONE);
  assign ovf_set   = rx_push & rx_full;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      ss_on   <= 1'b0;
      SPI_CLK <= 1'b0;
      SPI_DO  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          SPI_CLK <= ctrl[C_CPOL];
          if (start) begin
            // word start: timing/format config is sampled here and held for the word
            state   <= LOAD;
            cnt     <= '0;
            bit_cnt <= '0;
            cpol_q  <= ctrl[C_CPOL];
            cpha_q  <= ctrl[C_CPHA];
            lsb_q   <= ctrl[C_LSB];
            div_q   <= clkdiv;
            ss_on   <= 1'b1;
            if (!ctrl[C_CPHA]) begin
              SPI_DO <= out_bit(tx_dout, ctrl[C_LSB]);
              tx_sh  <= shift_out(tx_dout, ctrl[C_LSB]);
            end else begin
              tx_sh  <= tx_dout;
            end
          end else begin
            state <= IDLE;
            if (!ctrl[C_SS_HOLD]) ss_on <= 1'b0;
          end
        end
        LOAD: begin
          if (half_done) begin
            cnt     <= '0;
            state   <= LEAD;
            SPI_CLK <= ~cpol_q;
            if (cpha_q) begin
              SPI_DO <= out_bit(tx_sh, lsb_q);
              tx_sh  <= shift_out(tx_sh, lsb_q);
            end else begin
              rx_sh  <= shift_in(rx_sh, SPI_DI, lsb_q);
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        LEAD: begin
          if (half_done) begin
            cnt     <= '0;
            state   <= TRAIL;
            SPI_CLK <= cpol_q;
            bit_cnt <= bit_cnt + BW'(1);
            if (cpha_q) begin
              rx_sh  <= shift_in(rx_sh, SPI_DI, lsb_q);
            end else if (bit_cnt != BW'(DATA_W - 1)) begin
              SPI_DO <= out_bit(tx_sh, lsb_q);
              tx_sh  <= shift_out(tx_sh, lsb_q);
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        TRAIL: begin
          if (half_done) begin
            cnt <= '0;
            if (bit_cnt == BW'(DATA_W)) begin
              state <= DONE;
            end else begin
              state   <= LEAD;
              SPI_CLK <= ~cpol_q;
              if (cpha_q) begin
                SPI_DO <= out_bit(tx_sh, lsb_q);
                tx_sh  <= shift_out(tx_sh, lsb_q);
              end else begin
                rx_sh  <= shift_in(rx_sh, SPI_DI, lsb_q);
              end
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // select follows SS_SEL live; out-of-range selects match no output
  for (genvar i = 0; i < NUM_SS; i++) begin : g_ss
    assign SPI_SS_N[i] = ~(ss_on && (ctrl[C_SS_SEL +: 3] == 3'(i)));
  end

endmodule

// File: doc/apb_spi_master.md
Name: apb_spi_master

Overview:
Parametrised APB3 slave SPI master for the fabric side of the MSS, the successor to the fixed single-channel MSS SPI_1 peripheral. It is driven from the MSSPSEL/MSSPENABLE/MSSPWRITE/MSSPADDR/MSSPWDATA/MSSPRDATA/MSSPREADY/MSSPSLVERR bus. It adds a configurable word width, TX/RX FIFOs, multiple slave selects, all four CPOL/CPHA modes, and a held-select mode for CC3000 multi-byte frames. It also raises an interrupt to the MSS through an F2M GPI line.

Parameters:
DATA_W, 8, SPI word width in bits (4..32)
FIFO_DEPTH, 8, entries per TX and RX FIFO (power of two, >=2)
NUM_SS, 2, number of active-low slave-select outputs (1..8)
DIV_W, 8, clock-divider register width

Ports:
SYSCLK  in  1  fabric clock; the APB bus and the SPI engine both run on it
NSYSRESET  in  1  asynchronous active-low reset
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  APB write
PADDR  in  8  byte address; only [4:2] is decoded
PWDATA  in  32  write data
PRDATA  out  32  read data
PREADY  out  1  tied to 1, no wait states
PSLVERR  out  1  error response
SPI_CLK  out  1  serial clock
SPI_DO  out  1  MOSI
SPI_DI  in  1  MISO
SPI_SS_N  out  NUM_SS  slave selects, active low
IRQ  out  1  level interrupt

Behaviour:
- Reset (asynchronous, NSYSRESET low) returns the block to this state:
  - all registers 0 and both FIFOs empty;
  - PRDATA=0, PSLVERR=0, SPI_DO=0, SPI_SS_N=all 1, IRQ=0;
  - SPI_CLK=0, i.e. CPOL of the reset CTRL value.
- Reset asserted mid-transfer aborts the transfer immediately.
- Register map:
  - 0x00 CTRL (RW): [0] EN, [1] CPOL, [2] CPHA, [3] SS_HOLD, [6:4] SS_SEL, [7] LSB_FIRST, [8] IE_TXE, [9] IE_RXNE, [10] IE_OVF.
  - 0x04 CLKDIV (RW, [DIV_W-1:0]): SPI_CLK half-period = CLKDIV+1 SYSCLK cycles.
  - 0x08 STATUS: [0] BUSY, [1] TX_FULL, [2] TX_EMPTY, [3] RX_FULL, [4] RX_EMPTY, [5] RX_OVF (sticky, write-1-to-clear), [15:8] TX level, [23:16] RX level.
  - 0x0C TXDATA (WO): pushes PWDATA[DATA_W-1:0].
  - 0x10 RXDATA (RO): pops one word, zero-extended.
- APB access:
  - PRDATA is registered; valid in the access phase (PSEL & PENABLE).
  - The FIFO push/pop happens once, in the access phase.
- PSLVERR=1 during the access phase for any of:
  - an unmapped address (0x14..0x1C);
  - a write to TXDATA while TX is full (data dropped);
  - a read of RXDATA while RX is empty (PRDATA=0);
  - a write to STATUS or RXDATA, or a read of TXDATA.
- CTRL writes to CPOL, CPHA, CLKDIV or LSB_FIRST while BUSY take effect only at the next word start. SS_SEL and SS_HOLD take effect immediately.
- Engine FSM:
  - IDLE -> LOAD when EN=1 and TX is not empty. LOAD pops TX, loads the shift register and asserts the selected SS_N (index SS_SEL; SS_SEL>=NUM_SS selects nothing).
  - LOAD -> LEAD after 1 half-period (SS setup).
  - LEAD and TRAIL alternate, each one half-period long; DATA_W leading/trailing edge pairs per word.
    - CPHA=0: drive on LOAD and on each trailing edge; sample on leading edges.
    - CPHA=1: drive on leading edges; sample on trailing edges.
  - After the last trailing edge -> DONE. DONE pushes the received word to RX.
    - If RX is full, the word is dropped and RX_OVF is set.
  - DONE -> LOAD (back-to-back, SS kept low) if TX is not empty and EN=1.
  - Otherwise DONE -> IDLE. SS is released in DONE unless SS_HOLD=1.
- SS_HOLD: with SS_HOLD=1 the selected SS stays low in IDLE. Clearing SS_HOLD while in IDLE releases SS on the next cycle.
- Clearing EN mid-word finishes the current word, then goes to IDLE. TX is not flushed.
- SPI_CLK idles at CPOL. The leading edge is the transition away from CPOL.
- BUSY=1 in every state other than IDLE.
- IRQ = (IE_TXE & TX_EMPTY) | (IE_RXNE & ~RX_EMPTY) | (IE_OVF & RX_OVF), registered, 1-cycle latency.
- Simultaneous APB push and engine pop on a full TX FIFO: the push is rejected (full is evaluated before the pop). Same rule for RX pop vs engine push.
- FIFO pointers wrap modulo FIFO_DEPTH. Level counters are log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package apb_spi_pkg:
  - register offset constants (CTRL_A, CLKDIV_A, STATUS_A, TXDATA_A, RXDATA_A);
  - CTRL and STATUS bit-index constants;
  - engine state enum (IDLE, LOAD, LEAD, TRAIL, DONE).
- Sub-module spi_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level), instantiated twice: TX and RX.

Test Plan:
- Reset values: NSYSRESET low mid-transfer -> SPI_SS_N=2'b11, SPI_CLK=CPOL, IRQ=0, STATUS reads 0x00000014 after release.
- Mode 0 loopback (SPI_DO tied to SPI_DI), CLKDIV=1: write 0xA5 -> 8 SPI_CLK pulses, 4-SYSCLK period; RXDATA=0xA5; BUSY clears; SS_N[0] pulses low once.
- Mode 3, LSB_FIRST, slave model returns 0x3C: write 0x81 -> MOSI bit order 1,0,0,0,0,0,0,1; RXDATA=0x3C.
- SS_HOLD=1, SS_SEL=1, push 0x01,0x02,0x03 -> SS_N[1] low continuously, no gaps between words. Clear SS_HOLD -> SS_N=2'b11 next cycle.
- Overflow/errors: send FIFO_DEPTH+1 words without reading -> RX_OVF=1, IRQ=1 with IE_OVF. A 9th TXDATA write while full -> PSLVERR=1. RXDATA read while empty -> PSLVERR=1, PRDATA=0. Write 0x20 to STATUS -> RX_OVF cleared.
- Parameter sweep DATA_W=16, NUM_SS=4: write 0xBEEF in loopback -> RXDATA=0x0000BEEF. SS_SEL=5 -> no SS asserted.
